// File: rtl/rtype_operand_fetch.sv
// Operand-fetch/issue stage ahead of the R-type ALU: register file, scoreboard, registered output slot.
// Define RTYPE_OPFETCH_BYPASS_EN to forward a same-cycle writeback straight into a waiting source.
module rtype_operand_fetch #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_in1,
  output logic [XLEN-1:0] out_in2,
  output logic [4:0]      out_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);
  localparam logic [6:0] OPC_RTYPE = 7'b0110011;

  logic [XLEN-1:0]  rf_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             out_valid_q, illegal_q;
  logic [31:0]      instr_q;
  logic [XLEN-1:0]  in1_q, in2_q;
  logic [4:0]       rd_q;

  logic [4:0]      rd, rs1, rs2;
  logic            is_rtype, byp1, byp2, blk1, blk2, can_load, accept, load;
  logic [XLEN-1:0] op1, op2;

  assign is_rtype = (in_instr[6:0] == OPC_RTYPE);
  assign rd       = in_instr[11:7];
  assign rs1      = in_instr[19:15];
  assign rs2      = in_instr[24:20];

  always_comb begin
    byp1 = 1'b0;
    byp2 = 1'b0;
`ifdef RTYPE_OPFETCH_BYPASS_EN
    byp1 = wb_en && (wb_rd == rs1) && (rs1 != 5'd0);
    byp2 = wb_en && (wb_rd == rs2) && (rs2 != 5'd0);
`endif
  end

  always_comb begin
    op1 = '0;
    op2 = '0;
    if (rs1 != 5'd0) op1 = byp1 ? wb_data : rf_q[rs1];
    if (rs2 != 5'd0) op2 = byp2 ? wb_data : rf_q[rs2];
  end

  assign blk1     = (rs1 != 5'd0) && busy_q[rs1] && !byp1;
  assign blk2     = (rs2 != 5'd0) && busy_q[rs2] && !byp2;
  assign can_load = !out_valid_q || out_ready;
  assign in_ready = can_load && (!is_rtype || (!blk1 && !blk2));
  assign accept   = in_valid && in_ready;
  assign load     = accept && is_rtype;

  // Set is applied after clear so a same-cycle issue to a retiring register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_rd] = 1'b0;
    if (load)  busy_d[rd]    = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (wb_en && (wb_rd != 5'd0)) begin
      rf_q[wb_rd] <= wb_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q      <= '0;
      out_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      instr_q     <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      rd_q        <= '0;
    end else begin
      busy_q    <= busy_d;
      illegal_q <= accept && !is_rtype;
      if (load) begin
        out_valid_q <= 1'b1;
        instr_q     <= in_instr;
        in1_q       <= op1;
        in2_q       <= op2;
        rd_q        <= rd;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_instr = instr_q;
  assign out_in1   = in1_q;
  assign out_in2   = in2_q;
  assign out_rd    = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_rtype_operand_fetch.sv
// Bench for rtype_operand_fetch: directed hazard/backpressure/reset sequences, a vector table,
// and a randomized run against a queue-based reference model of the issue stage.
module tb_rtype_operand_fetch;
  localparam int XLEN = 32;
`ifdef RTYPE_OPFETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [31:0] ADD  = 32'h002081B3;
  localparam logic [31:0] SUB  = 32'h40118233;
  localparam logic [31:0] ADDI = 32'h00000013;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_ready, out_valid, out_ready, wb_en, illegal;
  logic [31:0]     in_instr, out_instr;
  logic [XLEN-1:0] out_in1, out_in2, wb_data;
  logic [4:0]      out_rd, wb_rd;

  always #5 clk = ~clk;

  rtype_operand_fetch #(.XLEN(XLEN), .NREGS(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_in1(out_in1), .out_in2(out_in2), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data), .illegal(illegal)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: architectural registers plus a list of issued-but-unretired destinations.
  logic [31:0] m_rf [32];
  int unsigned m_pend[$];
  bit          m_vld, m_ill;
  logic [31:0] m_instr, m_in1, m_in2;
  logic [4:0]  m_rd;

  typedef struct {
    logic [31:0] instr;
    bit          ill;
    logic [31:0] e1;
    logic [31:0] e2;
    logic [4:0]  erd;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_pending(input logic [4:0] r);
    if (r == 5'd0) return 1'b0;
    foreach (m_pend[i]) if (m_pend[i] == 32'(r)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] rt(input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    return {7'b0, s2, s1, 3'b000, d, 7'b0110011};
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 32; i++) m_rf[i] = '0;
    m_pend.delete();
    m_vld = 0; m_ill = 0;
    m_instr = '0; m_in1 = '0; m_in2 = '0; m_rd = '0;
  endtask

  task automatic cycle(input bit v, input logic [31:0] ins, input bit ordy,
                       input bit we, input logic [4:0] wr, input logic [31:0] wd);
    logic [4:0]  s1, s2, d;
    logic [31:0] o1, o2;
    bit          rtp, y1, y2, b1, b2, erdy, acc;
    @(negedge clk);
    in_valid = v; in_instr = ins; out_ready = ordy;
    wb_en = we; wb_rd = wr; wb_data = wd;
    #1;
    rtp = (ins[6:0] == 7'b0110011);
    d = ins[11:7]; s1 = ins[19:15]; s2 = ins[24:20];
    y1 = BYP && we && (wr == s1) && (s1 != 5'd0);
    y2 = BYP && we && (wr == s2) && (s2 != 5'd0);
    b1 = m_pending(s1) && !y1;
    b2 = m_pending(s2) && !y2;
    erdy = (!m_vld || ordy) && (!rtp || (!b1 && !b2));
    chk("in_ready", 32'(in_ready), 32'(erdy));
    acc = v && erdy;
    o1 = (s1 == 5'd0) ? 32'd0 : (y1 ? wd : m_rf[s1]);
    o2 = (s2 == 5'd0) ? 32'd0 : (y2 ? wd : m_rf[s2]);
    m_ill = acc && !rtp;
    if (acc && rtp) begin
      m_vld = 1; m_instr = ins; m_in1 = o1; m_in2 = o2; m_rd = d;
    end else if (ordy) begin
      m_vld = 0;
    end
    if (we && wr != 5'd0) m_rf[wr] = wd;
    if (we) for (int i = m_pend.size() - 1; i >= 0; i--) if (m_pend[i] == 32'(wr)) m_pend.delete(i);
    if (acc && rtp && d != 5'd0) m_pend.push_back(32'(d));
    @(posedge clk);
    #1;
    chk("out_valid", 32'(out_valid), 32'(m_vld));
    chk("illegal", 32'(illegal), 32'(m_ill));
    if (m_vld) begin
      chk("out_instr", out_instr, m_instr);
      chk("out_in1", out_in1, m_in1);
      chk("out_in2", out_in2, m_in2);
      chk("out_rd", 32'(out_rd), 32'(m_rd));
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'd0, 1'b1, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ins, wd;
    logic [4:0]  wr;
    tbl[0] = '{rt(5'd8, 5'd1, 5'd2),                 1'b0, 32'd101, 32'd102, 5'd8};
    tbl[1] = '{rt(5'd9, 5'd3, 5'd0),                 1'b0, 32'd103, 32'd0,   5'd9};
    tbl[2] = '{rt(5'd0, 5'd4, 5'd5),                 1'b0, 32'd104, 32'd105, 5'd0};
    tbl[3] = '{32'h40000000 | rt(5'd10, 5'd7, 5'd6), 1'b0, 32'd107, 32'd106, 5'd10};
    tbl[4] = '{ADDI,                                 1'b1, 32'd0,   32'd0,   5'd0};
    tbl[5] = '{rt(5'd11, 5'd0, 5'd0),                1'b0, 32'd0,   32'd0,   5'd11};
    tbl[6] = '{32'hFFFFFFFF,                         1'b1, 32'd0,   32'd0,   5'd0};
    tbl[7] = '{rt(5'd12, 5'd5, 5'd5),                1'b0, 32'd105, 32'd105, 5'd12};
    tbl[8] = '{rt(5'd13, 5'd6, 5'd1),                1'b0, 32'd106, 32'd101, 5'd13};

    rst = 1'b1;
    in_valid = 0; in_instr = '0; out_ready = 1; wb_en = 0; wb_rd = '0; wb_data = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_in1", out_in1, 32'd0);
    chk("rst_out_in2", out_in2, 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Preload, issue add, then dependent sub resolved by writeback of x3.
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd1, 32'd5);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd2, 32'd7);
    cycle(1'b1, ADD, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("add_vld", 32'(out_valid), 32'd1);
    chk("add_in1", out_in1, 32'd5);
    chk("add_in2", out_in2, 32'd7);
    chk("add_rd", 32'(out_rd), 32'd3);
    cycle(1'b1, SUB, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("sub_stall_vld", 32'(out_valid), 32'd0);
    cycle(1'b1, SUB, 1'b1, 1'b1, 5'd3, 32'd12);
`ifdef RTYPE_OPFETCH_BYPASS_EN
    chk("sub_byp_vld", 32'(out_valid), 32'd1);
`else
    chk("sub_nobyp_stall", 32'(out_valid), 32'd0);
    cycle(1'b1, SUB, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("sub_nobyp_vld", 32'(out_valid), 32'd1);
`endif
    chk("sub_instr", out_instr, SUB);
    chk("sub_in1", out_in1, 32'd12);
    chk("sub_in2", out_in2, 32'd5);

    // Backpressure: hold for three cycles, then replace without a bubble.
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, rt(5'd5, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 32'd0);
      chk("hold_instr", out_instr, SUB);
      chk("hold_in1", out_in1, 32'd12);
    end
    cycle(1'b1, rt(5'd5, 5'd1, 5'd2), 1'b1, 1'b0, 5'd0, 32'd0);
    chk("replace_vld", 32'(out_valid), 32'd1);
    chk("replace_instr", out_instr, rt(5'd5, 5'd1, 5'd2));

    // Non-R-type word and writes to x0.
    cycle(1'b1, ADDI, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("addi_illegal", 32'(illegal), 32'd1);
    chk("addi_vld", 32'(out_valid), 32'd0);
    idle();
    chk("addi_pulse_end", 32'(illegal), 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd0, 32'hDEADBEEF);
    cycle(1'b1, rt(5'd6, 5'd0, 5'd0), 1'b1, 1'b0, 5'd0, 32'd0);
    chk("x0_in1", out_in1, 32'd0);
    chk("x0_in2", out_in2, 32'd0);

    // Asynchronous reset in the middle of a stall.
    cycle(1'b1, ADD, 1'b1, 1'b0, 5'd0, 32'd0);
    cycle(1'b1, SUB, 1'b0, 1'b0, 5'd0, 32'd0);
    chk("pre_rst_vld", 32'(out_valid), 32'd1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_out_in1", out_in1, 32'd0);
    chk("arst_out_in2", out_in2, 32'd0);
    chk("arst_out_rd", 32'(out_rd), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    in_valid = 0;
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    cycle(1'b1, ADD, 1'b1, 1'b0, 5'd0, 32'd0);
    chk("post_rst_vld", 32'(out_valid), 32'd1);
    chk("post_rst_in1", out_in1, 32'd0);
    chk("post_rst_in2", out_in2, 32'd0);
    cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'd3, 32'd0);

    // Vector table on preloaded registers x1..x7 = 101..107.
    for (int i = 1; i < 8; i++) cycle(1'b0, 32'd0, 1'b1, 1'b1, 5'(i), 32'(100 + i));
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, tbl[i].instr, 1'b1, 1'b0, 5'd0, 32'd0);
      chk("tbl_illegal", 32'(illegal), 32'(tbl[i].ill));
      chk("tbl_vld", 32'(out_valid), 32'(!tbl[i].ill));
      if (!tbl[i].ill) begin
        chk("tbl_in1", out_in1, tbl[i].e1);
        chk("tbl_in2", out_in2, tbl[i].e2);
        chk("tbl_rd", 32'(out_rd), 32'(tbl[i].erd));
      end
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(0, 4) != 0) begin
        ins = $urandom;
        ins[6:0]   = 7'b0110011;
        ins[11:7]  = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
      end else begin
        ins = $urandom;
        if (ins[6:0] == 7'b0110011) ins[0] = 1'b0;
      end
      if (m_pend.size() > 0 && $urandom_range(0, 1) == 1)
        wr = 5'(m_pend[$urandom_range(0, m_pend.size() - 1)]);
      else
        wr = 5'($urandom_range(0, 7));
      wd = $urandom;
      cycle(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)), wr, wd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
